// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation and FSM
// encodings, MIPS funct codes and small operation-decode helpers.
package muldiv_hilo_pkg;

   typedef enum logic [1:0] {
      MULDIV_OP_MULT  = 2'b00,
      MULDIV_OP_MULTU = 2'b01,
      MULDIV_OP_DIV   = 2'b10,
      MULDIV_OP_DIVU  = 2'b11
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } muldiv_state_e;

   localparam logic [5:0] MFHI_FUNCT  = 6'h10;
   localparam logic [5:0] MTHI_FUNCT  = 6'h11;
   localparam logic [5:0] MFLO_FUNCT  = 6'h12;
   localparam logic [5:0] MTLO_FUNCT  = 6'h13;
   localparam logic [5:0] MULT_FUNCT  = 6'h18;
   localparam logic [5:0] MULTU_FUNCT = 6'h19;
   localparam logic [5:0] DIV_FUNCT   = 6'h1A;
   localparam logic [5:0] DIVU_FUNCT  = 6'h1B;

   function automatic logic op_is_div(input muldiv_op_e op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input muldiv_op_e op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/muldiv_hilo_core.sv
// Iterative radix-2 datapath: shift-add multiply or restoring divide on
// unsigned magnitudes. acc/sreg hold {HI,LO} product or {remainder,quotient}.
module muldiv_hilo_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             is_div_i,
   input  logic [WIDTH-1:0] a_mag_i,
   input  logic [WIDTH-1:0] b_mag_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] sreg_o,
   output logic [WIDTH-1:0] breg_o,
   output logic             last_o
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] breg_q, breg_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_diff;

   assign mul_sum  = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, breg_q} : '0);
   assign rem_sh   = {acc_q, sreg_q[WIDTH-1]};
   // The partial remainder is always below the divisor, so the difference fits WIDTH bits.
   assign rem_diff = rem_sh[WIDTH-1:0] - breg_q;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      acc_d  = acc_q;
      sreg_d = sreg_q;
      breg_d = breg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         acc_d  = '0;
         sreg_d = a_mag_i;
         breg_d = b_mag_i;
         cnt_d  = '0;
      end else if (step_i) begin
         cnt_d = cnt_q + 1'b1;
         if (is_div_i) begin
            if (rem_sh >= {1'b0, breg_q}) begin
               acc_d  = rem_diff;
               sreg_d = {sreg_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d  = rem_sh[WIDTH-1:0];
               sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d  = mul_sum[WIDTH:1];
            sreg_d = {mul_sum[0], sreg_q[WIDTH-1:1]};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q  <= '0;
         sreg_q <= '0;
         breg_q <= '0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         sreg_q <= sreg_d;
         breg_q <= breg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign acc_o  = acc_q;
   assign sreg_o = sreg_q;
   assign breg_o = breg_q;
   assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO multiply/divide unit: FSM, sign handling, HI/LO registers and stall.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module muldiv_hilo
   import muldiv_hilo_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic             hilo_read,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST_MUL = 1'b1;
`else
   localparam bit FAST_MUL = 1'b0;
`endif

   muldiv_state_e    state_q, state_d;
   muldiv_op_e       op_q, op_d, op_in;
   logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d;

   logic             a_neg_in, b_neg_in;
   logic [WIDTH-1:0] a_mag_in, b_mag_in;
   logic             core_load, core_step, core_last;
   logic [WIDTH-1:0] core_acc, core_sreg, core_breg;
   logic [2*WIDTH-1:0] prod_mag, prod;
   logic [WIDTH-1:0] quot, rem;

   assign op_in    = muldiv_op_e'(op);
   assign a_neg_in = op_is_signed(op_in) & operand_a[WIDTH-1];
   assign b_neg_in = op_is_signed(op_in) & operand_b[WIDTH-1];
   assign a_mag_in = a_neg_in ? -operand_a : operand_a;
   assign b_mag_in = b_neg_in ? -operand_b : operand_b;

   muldiv_hilo_core #(.WIDTH(WIDTH)) u_core (
      .clock    (clock),
      .reset    (reset),
      .load_i   (core_load),
      .step_i   (core_step),
      .is_div_i (op_is_div(op_q)),
      .a_mag_i  (a_mag_in),
      .b_mag_i  (b_mag_in),
      .acc_o    (core_acc),
      .sreg_o   (core_sreg),
      .breg_o   (core_breg),
      .last_o   (core_last)
   );

`ifdef MULDIV_FAST_MUL_EN
   assign prod_mag = {{WIDTH{1'b0}}, core_sreg} * {{WIDTH{1'b0}}, core_breg};
`else
   assign prod_mag = {core_acc, core_sreg};
`endif

   // Division by zero leaves the dividend magnitude in acc, so HI comes back as operand_a.
   assign prod = (a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag;
   assign quot = (core_breg == '0)    ? '1
               : (a_neg_q ^ b_neg_q)  ? -core_sreg : core_sreg;
   assign rem  = a_neg_q ? -core_acc : core_acc;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_neg_d   = a_neg_q;
      b_neg_d   = b_neg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               core_load = 1'b1;
               op_d      = op_in;
               a_neg_d   = a_neg_in;
               b_neg_d   = b_neg_in;
               state_d   = (FAST_MUL && !op_is_div(op_in)) ? SIGN : CALC;
            end else begin
               if (mthi) hi_d = operand_a;
               if (mtlo) lo_d = operand_a;
            end
         end
         CALC: begin
            core_step = 1'b1;
            if (core_last) state_d = SIGN;
         end
         SIGN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (op_is_div(op_q)) begin
               hi_d = rem;
               lo_d = quot;
            end else begin
               {hi_d, lo_d} = prod;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= MULDIV_OP_MULT;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign done  = done_q;
   assign busy  = (state_q != IDLE);
   assign stall = busy & (start | hilo_read | mthi | mtlo);

endmodule
